// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - in-order write queue in front of the register file write port
// Optional: WQ_COALESCE_EN merges a push into the youngest entry when the index matches.
module regfile_write_queue #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [4:0]             inReg,
    input  logic [DATAWIDTH-1:0]   inData,
    output logic                   write,
    output logic [4:0]             writeReg,
    output logic [DATAWIDTH-1:0]   writeData,
    input  logic                   writeStall,
    input  logic [4:0]             queryReg1,
    input  logic [4:0]             queryReg2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [DATAWIDTH-1:0]   hitData1,
    output logic [DATAWIDTH-1:0]   hitData2,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]        head_q, head_d;
    logic [AW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [4:0]           reg_q  [DEPTH];
    logic [DATAWIDTH-1:0] data_q [DEPTH];

    logic          store;
    logic          coalesce;
    logic          alloc;
    logic          pop;
    logic [AW-1:0] tail_m1;
    logic [AW-1:0] slot;

    assign inReady   = (count_q < CW'(DEPTH)) && !flush;
    assign store     = inValid && inReady && (inReg != 5'd0);
    assign write     = (count_q != '0) && !writeStall;
    assign pop       = write;
    assign writeReg  = reg_q[head_q];
    assign writeData = data_q[head_q];
    assign count     = count_q;
    assign tail_m1   = tail_q - 1'b1;

`ifdef WQ_COALESCE_EN
    // The youngest entry may only absorb a push if it is not leaving this cycle.
    assign coalesce = store && (count_q != '0) && (reg_q[tail_m1] == inReg)
                      && !(pop && (count_q == CW'(1)));
`else
    assign coalesce = 1'b0;
`endif

    assign alloc = store && !coalesce;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)   head_d = head_q + 1'b1;
            if (alloc) tail_d = tail_q + 1'b1;
            if (alloc && !pop)      count_d = count_q + 1'b1;
            else if (!alloc && pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            reg_q[tail_q]  <= inReg;
            data_q[tail_q] <= inData;
        end else if (coalesce) begin
            data_q[tail_m1] <= inData;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        slot     = head_q;
        hit1     = 1'b0;
        hit2     = 1'b0;
        hitData1 = '0;
        hitData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + AW'(i);
            if (CW'(i) < count_q) begin
                if ((queryReg1 != 5'd0) && (reg_q[slot] == queryReg1)) begin
                    hit1     = 1'b1;
                    hitData1 = data_q[slot];
                end
                if ((queryReg2 != 5'd0) && (reg_q[slot] == queryReg2)) begin
                    hit2     = 1'b1;
                    hitData2 = data_q[slot];
                end
            end
        end
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the integer register file's single write port.
- Buffers writeback results (register index + data) from multi-cycle producers in a small FIFO, then drains them in order to the register file, one per cycle, honouring a stall from the port owner.
- Exposes a youngest-match lookup on two read indices, so decode can detect and forward values still pending in the queue.

Parameters:
- DATAWIDTH, 32, width of register data.
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all pending entries.
- inValid  in  1  producer has a writeback request.
- inReady  out  1  queue can accept a request this cycle.
- inReg  in  5  destination register index.
- inData  in  DATAWIDTH  destination data.
- write  out  1  write enable to register file.
- writeReg  out  5  register file write address (head entry).
- writeData  out  DATAWIDTH  register file write data (head entry).
- writeStall  in  1  register file port not available this cycle.
- queryReg1  in  5  first lookup index.
- queryReg2  in  5  second lookup index.
- hit1  out  1  a pending entry targets queryReg1.
- hit2  out  1  a pending entry targets queryReg2.
- hitData1  out  DATAWIDTH  data of youngest entry matching queryReg1.
- hitData2  out  DATAWIDTH  data of youngest entry matching queryReg2.
- count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage: circular buffer with head/tail pointers and an occupancy counter. Pointers wrap modulo DEPTH.
- Reset (rst_n=0, async):
  - head, tail and count go to 0.
  - Outputs: write=0, hit1=hit2=0, inReady=1 after release.
  - Data array is not reset.
- Accept rule:
  - inReady = (count < DEPTH) && !flush. It does not depend on the same-cycle pop, so there is no combinational path from writeStall to inReady.
  - A push occurs when inValid && inReady.
  - If inReg == 0, the handshake still completes but nothing is stored (x0 writes are dropped).
- Drain rule:
  - write = (count != 0) && !writeStall. writeReg/writeData are the head entry and are combinational from storage.
  - A pop occurs when write=1.
  - writeReg/writeData hold the head value even when write=0; they are don't-care when empty.
- Latency:
  - A request accepted at edge N drives write during cycle N+1 (if not stalled).
  - It lands in the register file at edge N+1.
  - Minimum latency is one cycle; order is strictly FIFO.
- Simultaneous push and pop: both take effect and count is unchanged. Not possible when full, because inReady=0.
- Full: count == DEPTH. inReady=0; pop continues when unstalled.
- Empty: write=0; a push this cycle is not visible at the output until the next cycle (no same-cycle pass-through).
- Lookup:
  - hitN=1 if any valid entry has index == queryRegN and queryRegN != 0.
  - hitDataN is the data of the youngest such entry (closest to tail). The head entry counts even if it is being written this cycle.
  - Purely combinational. hitDataN=0 when hitN=0.
- Flush:
  - At the next edge, head=tail=0 and count=0.
  - A same-cycle push is refused (inReady=0); a same-cycle write still reaches the register file.
- writeStall held indefinitely: the queue fills and then back-pressures via inReady; no data is lost.

Optional Feature:
- Macro: WQ_COALESCE_EN.
- Defined: a push whose inReg equals the index of the current tail entry (youngest) overwrites that entry's data in place instead of allocating, unless that entry is also the head being popped this cycle (in which case it allocates normally).
  - count is unchanged on a coalesced push.
  - inReady rule is unchanged.
- Undefined: every non-x0 push allocates a new entry.

Test Plan:
- Reset, then push (5, 0x1234_5678) with writeStall=0 -> write=1, writeReg=5, writeData=0x12345678 exactly one cycle later; count returns to 0.
- writeStall=1, push (1,0xA), (2,0xB), (3,0xC), (4,0xD) -> count=4, inReady=0; release stall -> four writes in order 1,2,3,4 on consecutive cycles.
- Push (0, 0xFFFF_FFFF) -> handshake completes, count stays 0, write never asserts.
- Stalled queue holding (7,0x11), (7,0x22), queryReg1=7, queryReg2=0 -> hit1=1, hitData1=0x22, hit2=0.
- Queue holding 3 entries, assert flush together with inValid -> inReady=0, next cycle count=0, write=0.
- With WQ_COALESCE_EN, stalled, push (9,0x1) then (9,0x2) -> count=1, drains single write 9<-0x2; without the macro -> count=2, two writes.
- Assert rst_n=0 mid-drain with 2 entries -> write drops immediately, count=0.
